// File: rtl/scoreboard_ctl.sv
// Scoreboard issue/sequencing controller for two mathers and one memoreer.
// Tracks RAW/WAW/WAR hazards and sequences operand read, execute and writeback per unit.
`timescale 1ns/1ps
module scoreboard_ctl #(
    parameter int OP_W     = 3,
    parameter int REG_W    = 3,
    parameter int SINK_REG = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               issue_valid,
    input  logic [OP_W-1:0]    issue_op,
    input  logic [REG_W-1:0]   issue_dest,
    input  logic [REG_W-1:0]   issue_src0,
    input  logic [REG_W-1:0]   issue_src1,
    output logic               issue_stall,
    input  logic [2:0]         fu_done,
    output logic [2:0]         fu_start,
    output logic [2:0]         fu_wb,
    output logic [3*OP_W-1:0]  fu_op,
    output logic [3*REG_W-1:0] fu_dest,
    output logic [3*REG_W-1:0] fu_src0,
    output logic [3*REG_W-1:0] fu_src1,
    output logic [2:0]         fu_busy
);

    typedef enum logic [1:0] {IDLE, WAIT_OPS, EXEC, WAIT_WB} unit_state_e;

    localparam logic [1:0]       NONE     = 2'd3;
    localparam logic [REG_W-1:0] SINK     = REG_W'(SINK_REG);
    localparam logic [OP_W-1:0]  OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0]  OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0]  OP_LOAD  = OP_W'(2);
    localparam logic [OP_W-1:0]  OP_STORE = OP_W'(3);

    unit_state_e      state_q [3], state_d [3];
    logic [OP_W-1:0]  op_q    [3], op_d    [3];
    logic [REG_W-1:0] fi_q    [3], fi_d    [3];
    logic [REG_W-1:0] fj_q    [3], fj_d    [3];
    logic [REG_W-1:0] fk_q    [3], fk_d    [3];
    logic [1:0]       qj_q    [3], qj_d    [3];
    logic [1:0]       qk_q    [3], qk_d    [3];
    logic             rj_q    [3], rj_d    [3];
    logic             rk_q    [3], rk_d    [3];
    logic [1:0]       status_q[8], status_d[8];

    logic [2:0]       war;
    logic             is_math, is_mem, waw_ok, do_issue;
    logic [1:0]       tgt, new_qj, new_qk;
    logic [REG_W-1:0] new_fi, new_fk;

    // A source's producer that is writing back right now counts as already done.
    function automatic logic [1:0] src_producer(input logic [REG_W-1:0] r,
                                                input logic [1:0] stat,
                                                input logic [2:0] wbv);
        if (r == SINK || stat == NONE) return NONE;
        if (wbv[stat]) return NONE;
        return stat;
    endfunction

    always_comb begin
        war = '0;
        fu_start = '0;
        fu_wb = '0;
        for (int k = 0; k < 3; k++) begin
            fu_start[k] = (state_q[k] == WAIT_OPS) && rj_q[k] && rk_q[k];
            if (fi_q[k] != SINK) begin
                for (int f = 0; f < 3; f++) begin
                    if (state_q[f] == WAIT_OPS &&
                        ((fj_q[f] == fi_q[k] && rj_q[f]) || (fk_q[f] == fi_q[k] && rk_q[f])))
                        war[k] = 1'b1;
                end
            end
            fu_wb[k] = (state_q[k] == WAIT_WB) && !war[k];
        end
    end

    always_comb begin
        is_math = (issue_op == OP_ADD) || (issue_op == OP_SUB);
        is_mem  = (issue_op == OP_LOAD) || (issue_op == OP_STORE);
        tgt = NONE;
        if (is_math) begin
            if (state_q[0] == IDLE)      tgt = 2'd0;
            else if (state_q[1] == IDLE) tgt = 2'd1;
        end else if (is_mem && state_q[2] == IDLE) begin
            tgt = 2'd2;
        end
        new_fi = (issue_op == OP_STORE) ? SINK : issue_dest;
        new_fk = (issue_op == OP_LOAD) ? SINK : issue_src1;
        waw_ok = (new_fi == SINK) || (status_q[new_fi] == NONE);
        do_issue = issue_valid && (tgt != NONE) && waw_ok;
        issue_stall = issue_valid && (is_math || is_mem) && !do_issue;
        new_qj = src_producer(issue_src0, status_q[issue_src0], fu_wb);
        new_qk = src_producer(new_fk, status_q[new_fk], fu_wb);
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            state_d[k] = state_q[k];
            op_d[k] = op_q[k];
            fi_d[k] = fi_q[k];
            fj_d[k] = fj_q[k];
            fk_d[k] = fk_q[k];
            qj_d[k] = qj_q[k];
            qk_d[k] = qk_q[k];
            rj_d[k] = rj_q[k];
            rk_d[k] = rk_q[k];
            case (state_q[k])
                IDLE: begin
                    if (do_issue && tgt == 2'(k)) begin
                        state_d[k] = WAIT_OPS;
                        op_d[k] = issue_op;
                        fi_d[k] = new_fi;
                        fj_d[k] = issue_src0;
                        fk_d[k] = new_fk;
                        qj_d[k] = new_qj;
                        qk_d[k] = new_qk;
                        rj_d[k] = (new_qj == NONE);
                        rk_d[k] = (new_qk == NONE);
                    end
                end
                WAIT_OPS: begin
                    if (fu_start[k]) begin
                        state_d[k] = EXEC;
                        rj_d[k] = 1'b0;
                        rk_d[k] = 1'b0;
                    end else begin
                        for (int w = 0; w < 3; w++) begin
                            if (fu_wb[w] && qj_q[k] == 2'(w)) begin
                                qj_d[k] = NONE;
                                rj_d[k] = 1'b1;
                            end
                            if (fu_wb[w] && qk_q[k] == 2'(w)) begin
                                qk_d[k] = NONE;
                                rk_d[k] = 1'b1;
                            end
                        end
                    end
                end
                EXEC:    if (fu_done[k]) state_d[k] = WAIT_WB;
                WAIT_WB: if (fu_wb[k]) state_d[k] = IDLE;
                default: state_d[k] = IDLE;
            endcase
        end
        // WAW exclusion means a new claim never targets an entry being released.
        for (int r = 0; r < 8; r++) status_d[r] = status_q[r];
        for (int k = 0; k < 3; k++) begin
            if (fu_wb[k] && fi_q[k] != SINK && status_q[fi_q[k]] == 2'(k))
                status_d[fi_q[k]] = NONE;
        end
        if (do_issue && new_fi != SINK) status_d[new_fi] = tgt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= IDLE;
                op_q[k] <= '0;
                fi_q[k] <= '0;
                fj_q[k] <= '0;
                fk_q[k] <= '0;
                qj_q[k] <= NONE;
                qk_q[k] <= NONE;
                rj_q[k] <= 1'b0;
                rk_q[k] <= 1'b0;
            end
            for (int r = 0; r < 8; r++) status_q[r] <= NONE;
        end else begin
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= state_d[k];
                op_q[k] <= op_d[k];
                fi_q[k] <= fi_d[k];
                fj_q[k] <= fj_d[k];
                fk_q[k] <= fk_d[k];
                qj_q[k] <= qj_d[k];
                qk_q[k] <= qk_d[k];
                rj_q[k] <= rj_d[k];
                rk_q[k] <= rk_d[k];
            end
            for (int r = 0; r < 8; r++) status_q[r] <= status_d[r];
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            fu_op[OP_W*k +: OP_W] = op_q[k];
            fu_dest[REG_W*k +: REG_W] = fi_q[k];
            fu_src0[REG_W*k +: REG_W] = fj_q[k];
            fu_src1[REG_W*k +: REG_W] = fk_q[k];
            fu_busy[k] = (state_q[k] != IDLE);
        end
    end

endmodule

// File: tb/tb_scoreboard_ctl.sv
// Directed self-checking bench for scoreboard_ctl: issue, RAW/WAW/WAR hazards,
// structural stalls and mid-operation reset, with hand-computed expectations.
`timescale 1ns/1ps
module tb_scoreboard_ctl;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, LOAD = 3'd2, STORE = 3'd3, NOP = 3'd4;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [2:0] issue_op, issue_dest, issue_src0, issue_src1;
    logic       issue_stall;
    logic [2:0] fu_done, fu_start, fu_wb, fu_busy;
    logic [8:0] fu_op, fu_dest, fu_src0, fu_src1;

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;

    scoreboard_ctl dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_dest(issue_dest),
        .issue_src0(issue_src0), .issue_src1(issue_src1), .issue_stall(issue_stall),
        .fu_done(fu_done), .fu_start(fu_start), .fu_wb(fu_wb),
        .fu_op(fu_op), .fu_dest(fu_dest), .fu_src0(fu_src0), .fu_src1(fu_src1),
        .fu_busy(fu_busy)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge; outputs are observed 1ns later still.
    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [2:0] d,
                                 input logic [2:0] s0, input logic [2:0] s1,
                                 input logic [2:0] done);
        issue_valid = v;
        issue_op = op;
        issue_dest = d;
        issue_src0 = s0;
        issue_src1 = s1;
        fu_done = done;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, NOP, 0, 0, 0, 0);
        #11;
        checkOutput("rst_busy", 32'(fu_busy), 0);
        checkOutput("rst_start", 32'(fu_start), 0);
        checkOutput("rst_wb", 32'(fu_wb), 0);
        checkOutput("rst_op", 32'(fu_op), 0);
        checkOutput("rst_dest", 32'(fu_dest), 0);
        checkOutput("rst_src0", 32'(fu_src0), 0);
        checkOutput("rst_src1", 32'(fu_src1), 0);
        checkOutput("rst_stall", 32'(issue_stall), 0);
        reset = 1'b0;

        // NOP and reserved codes are accepted without occupying a unit
        applyStimulus(1, NOP, 1, 2, 3, 0);
        checkOutput("nop_stall", 32'(issue_stall), 0);
        tick();
        applyStimulus(1, 3'd6, 1, 2, 3, 0);
        checkOutput("nop_busy", 32'(fu_busy), 0);
        checkOutput("op6_stall", 32'(issue_stall), 0);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("op6_busy", 32'(fu_busy), 0);

        // Basic ADD r1=r2+r3 at minimum latency
        applyStimulus(1, ADD, 1, 2, 3, 0);
        checkOutput("t1_stall", 32'(issue_stall), 0);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t1_start", 32'(fu_start), 3'b001);
        checkOutput("t1_src0", 32'(fu_src0[2:0]), 2);
        checkOutput("t1_src1", 32'(fu_src1[2:0]), 3);
        checkOutput("t1_busy", 32'(fu_busy), 3'b001);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 3'b001);
        checkOutput("t1_start_exec", 32'(fu_start), 0);
        checkOutput("t1_wb_exec", 32'(fu_wb), 0);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t1_wb", 32'(fu_wb), 3'b001);
        tick();
        applyStimulus(1, LOAD, 1, 0, 0, 0);
        checkOutput("t1_idle", 32'(fu_busy), 0);
        checkOutput("t1_wb_done", 32'(fu_wb), 0);
        checkOutput("t1_r1_free", 32'(issue_stall), 0);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("ld_start", 32'(fu_start), 3'b100);
        checkOutput("ld_op", 32'(fu_op[8:6]), 2);
        checkOutput("ld_dest", 32'(fu_dest[8:6]), 1);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 3'b100);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("ld_wb", 32'(fu_wb), 3'b100);
        tick();

        // RAW: SUB r4=r1-r2 waits for ADD r1
        applyStimulus(1, ADD, 1, 2, 3, 0);
        tick();
        applyStimulus(1, SUB, 4, 1, 2, 0);
        checkOutput("t2_stall", 32'(issue_stall), 0);
        checkOutput("t2_add_start", 32'(fu_start), 3'b001);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 3'b001);
        checkOutput("t2_sub_wait", 32'(fu_start), 0);
        checkOutput("t2_sub_unit", 32'(fu_src0[5:3]), 1);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t2_add_wb", 32'(fu_wb), 3'b001);
        checkOutput("t2_sub_wait2", 32'(fu_start), 0);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t2_sub_start", 32'(fu_start), 3'b010);
        checkOutput("t2_no_wb", 32'(fu_wb), 0);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 3'b010);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t2_sub_wb", 32'(fu_wb), 3'b010);
        tick();
        checkOutput("t2_idle", 32'(fu_busy), 0);

        // Structural: third ADD waits for a free mather
        applyStimulus(1, ADD, 1, 5, 6, 0);
        tick();
        applyStimulus(1, ADD, 2, 5, 6, 0);
        checkOutput("t3_second", 32'(issue_stall), 0);
        checkOutput("t3_start0", 32'(fu_start), 3'b001);
        tick();
        applyStimulus(1, ADD, 3, 5, 6, 3'b001);
        checkOutput("t3_full", 32'(issue_stall), 1);
        checkOutput("t3_start1", 32'(fu_start), 3'b010);
        tick();
        applyStimulus(1, ADD, 3, 5, 6, 0);
        checkOutput("t3_full_wb", 32'(issue_stall), 1);
        checkOutput("t3_wb0", 32'(fu_wb), 3'b001);
        tick();
        applyStimulus(1, ADD, 3, 5, 6, 0);
        checkOutput("t3_issue", 32'(issue_stall), 0);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 3'b010);
        checkOutput("t3_start_again", 32'(fu_start), 3'b001);
        checkOutput("t3_dest", 32'(fu_dest[2:0]), 3);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 3'b001);
        checkOutput("t3_wb1", 32'(fu_wb), 3'b010);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t3_wb0b", 32'(fu_wb), 3'b001);
        tick();
        checkOutput("t3_idle", 32'(fu_busy), 0);

        // WAW: LOAD r5 behind ADD r5
        applyStimulus(1, ADD, 5, 1, 2, 0);
        tick();
        applyStimulus(1, LOAD, 5, 3, 0, 0);
        checkOutput("t4_waw1", 32'(issue_stall), 1);
        tick();
        applyStimulus(1, LOAD, 5, 3, 0, 3'b001);
        checkOutput("t4_waw2", 32'(issue_stall), 1);
        tick();
        applyStimulus(1, LOAD, 5, 3, 0, 0);
        checkOutput("t4_waw_wbcycle", 32'(issue_stall), 1);
        checkOutput("t4_add_wb", 32'(fu_wb), 3'b001);
        tick();
        applyStimulus(1, LOAD, 5, 3, 0, 0);
        checkOutput("t4_issue", 32'(issue_stall), 0);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t4_busy", 32'(fu_busy), 3'b100);
        checkOutput("t4_start", 32'(fu_start), 3'b100);
        checkOutput("t4_op", 32'(fu_op[8:6]), 2);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 3'b100);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t4_ld_wb", 32'(fu_wb), 3'b100);
        tick();

        // WAR: ADD r6 must not write back before SUB r4=r1-r6 reads r6
        applyStimulus(1, LOAD, 1, 0, 0, 0);
        tick();
        applyStimulus(1, SUB, 4, 1, 6, 0);
        checkOutput("t5_sub_stall", 32'(issue_stall), 0);
        checkOutput("t5_ld_start", 32'(fu_start), 3'b100);
        tick();
        applyStimulus(1, ADD, 6, 2, 3, 0);
        checkOutput("t5_add_stall", 32'(issue_stall), 0);
        checkOutput("t5_sub_wait", 32'(fu_start), 0);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t5_add_start", 32'(fu_start), 3'b010);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 3'b010);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t5_war_hold", 32'(fu_wb), 0);
        checkOutput("t5_busy", 32'(fu_busy), 3'b111);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 3'b100);
        checkOutput("t5_war_hold2", 32'(fu_wb), 0);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t5_ld_wb", 32'(fu_wb), 3'b100);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t5_sub_start", 32'(fu_start), 3'b001);
        checkOutput("t5_war_hold3", 32'(fu_wb), 0);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t5_add_wb", 32'(fu_wb), 3'b010);
        checkOutput("t5_no_restart", 32'(fu_start), 0);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 3'b001);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t5_sub_wb", 32'(fu_wb), 3'b001);
        tick();
        checkOutput("t5_idle", 32'(fu_busy), 0);

        // Reset while mather 0 executes
        applyStimulus(1, ADD, 1, 2, 3, 0);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        tick();
        checkOutput("t6_exec_busy", 32'(fu_busy), 3'b001);
        reset = 1'b1;
        applyStimulus(0, NOP, 0, 0, 0, 3'b001);
        checkOutput("t6_rst_busy", 32'(fu_busy), 0);
        checkOutput("t6_rst_wb", 32'(fu_wb), 0);
        tick();
        reset = 1'b0;
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t6_post_wb", 32'(fu_wb), 0);
        tick();
        applyStimulus(1, ADD, 1, 4, 5, 0);
        checkOutput("t6_issue", 32'(issue_stall), 0);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t6_unit0", 32'(fu_busy), 3'b001);
        checkOutput("t6_start", 32'(fu_start), 3'b001);
        checkOutput("t6_src0", 32'(fu_src0[2:0]), 4);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 3'b001);
        tick();
        applyStimulus(0, NOP, 0, 0, 0, 0);
        checkOutput("t6_wb", 32'(fu_wb), 3'b001);
        tick();
        checkOutput("t6_idle", 32'(fu_busy), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
